// File: rtl/sequential_divider.sv
// Sequential unsigned divider using a restoring shift-subtract loop.
// One quotient bit is produced per clock, so a division takes WIDTH
// cycles in RUN. A zero divisor skips RUN and reports all-ones
// quotient with the dividend as remainder.
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  // Dividend register; quotient bits are shifted in from the bottom as
  // dividend bits leave from the top, so it ends up holding the quotient.
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;

  // One restoring step. The shifted remainder and the trial difference
  // are WIDTH+1 bits wide so the bit shifted out of r_rem is not lost;
  // the top bit of the difference is the borrow.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  // Combinational shift-subtract step feeding the RUN state.
  always_comb begin
    w_rem_sh = {r_rem, r_dividend[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_divisor};
    w_ge     = ~w_diff[WIDTH];
    w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_nx = {r_dividend[WIDTH-2:0], w_ge};
  end

  // Control FSM with registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (start) begin
            r_dividend <= in1;
            r_divisor  <= in2;
            r_rem      <= '0;
            r_cnt      <= '0;
            if (in2 == '0) begin
              r_state     <= S_DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= in1;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_dividend <= w_quo_nx;
          r_rem      <= w_rem_nx;
          r_cnt      <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= w_quo_nx;
            remainder <= w_rem_nx;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Testbench for sequential_divider (WIDTH=4): directed scenarios plus
// exhaustive and randomized operands against an arithmetic reference.
module tb_sequential_divider;

  localparam int W = 4;
  localparam int TIMEOUT = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  integer errors = 0;
  integer checks = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in1(in1),
    .in2(in2),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer division with the zero-divisor rule.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Expected number of edges after the accepting edge until done is seen.
  function automatic int ref_lat(input int b);
    return (b == 0) ? 0 : W;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division and wait (bounded) for done. Reports results,
  // latency, busy-cycle count, and the state one edge after done.
  task automatic run_op(input int a, input int b, input bit scramble,
                        output int q, output int r, output int z,
                        output int lat, output int bcnt,
                        output int d_after, output int z_after,
                        output int q_after, output int r_after,
                        output bit timed_out);
    @(negedge clk);
    start = 1'b1;
    in1   = W'(a);
    in2   = W'(b);
    tick();
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    timed_out = 1'b0;
    while (!done && lat < TIMEOUT) begin
      if (busy) bcnt++;
      if (scramble) begin
        in1 = W'($urandom);
        in2 = W'($urandom);
      end
      tick();
      lat++;
    end
    if (!done) timed_out = 1'b1;
    q = int'(quotient);
    r = int'(remainder);
    z = int'(div_by_zero);
    tick();
    d_after = int'(done);
    z_after = int'(div_by_zero);
    q_after = int'(quotient);
    r_after = int'(remainder);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    in1 = 4'd13;
    in2 = 4'd3;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b dz=%0b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after: got busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int q, r, z, lat, bc, da, za, qa, ra;
    bit to;
    run_op(13, 3, 1'b0, q, r, z, lat, bc, da, za, qa, ra, to);
    checks++;
    if (to || q !== 4 || r !== 1 || z !== 0) begin
      errors++;
      $display("FAIL basic_13_3: got q=%0d r=%0d dz=%0d timeout=%0b, want q=4 r=1 dz=0",
               q, r, z, to);
    end
    checks++;
    if (lat !== W || bc !== W) begin
      errors++;
      $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d, want %0d %0d",
               lat, bc, W, W);
    end
    checks++;
    if (da !== 0 || qa !== 4 || ra !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_hold: got done=%0d q=%0d r=%0d busy=%0b, want 0 4 1 0",
               da, qa, ra, busy);
    end
  endtask

  task automatic test_div_zero();
    int q, r, z, lat, bc, da, za, qa, ra;
    bit to;
    run_op(7, 0, 1'b0, q, r, z, lat, bc, da, za, qa, ra, to);
    checks++;
    if (to || q !== 15 || r !== 7 || z !== 1) begin
      errors++;
      $display("FAIL divzero_result: got q=%0d r=%0d dz=%0d, want q=15 r=7 dz=1", q, r, z);
    end
    checks++;
    if (lat !== 0 || bc !== 0) begin
      errors++;
      $display("FAIL divzero_timing: got latency=%0d busy_cycles=%0d, want 0 0", lat, bc);
    end
    checks++;
    if (da !== 0 || za !== 0 || qa !== 15 || ra !== 7) begin
      errors++;
      $display("FAIL divzero_after: got done=%0d dz=%0d q=%0d r=%0d, want 0 0 15 7",
               da, za, qa, ra);
    end
  endtask

  task automatic test_edges();
    int q, r, z, lat, bc, da, za, qa, ra;
    bit to;
    run_op(2, 9, 1'b0, q, r, z, lat, bc, da, za, qa, ra, to);
    checks++;
    if (to || q !== 0 || r !== 2 || z !== 0) begin
      errors++;
      $display("FAIL edge_2_9: got q=%0d r=%0d dz=%0d, want 0 2 0", q, r, z);
    end
    run_op(15, 1, 1'b0, q, r, z, lat, bc, da, za, qa, ra, to);
    checks++;
    if (to || q !== 15 || r !== 0 || z !== 0) begin
      errors++;
      $display("FAIL edge_15_1: got q=%0d r=%0d dz=%0d, want 15 0 0", q, r, z);
    end
  endtask

  task automatic test_ignore_start();
    int q, r, z, lat, bc, da, za, qa, ra;
    int extra_done;
    bit to;
    @(negedge clk);
    start = 1'b1;
    in1 = 4'd13;
    in2 = 4'd3;
    tick();
    in1 = 4'd15;
    in2 = 4'd5;
    tick();
    tick();
    start = 1'b0;
    in1 = 4'd6;
    in2 = 4'd1;
    lat = 2;
    while (!done && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    checks++;
    if (!done || quotient !== 4'd4 || remainder !== 4'd1 || lat !== W) begin
      errors++;
      $display("FAIL ignore_start_result: got done=%0b q=%0d r=%0d latency=%0d, want 1 4 1 %0d",
               done, quotient, remainder, lat, W);
    end
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin
      errors++;
      $display("FAIL ignore_start_queued: got %0d busy/done cycles, want 0", extra_done);
    end
    run_op(15, 5, 1'b0, q, r, z, lat, bc, da, za, qa, ra, to);
    checks++;
    if (to || q !== 3 || r !== 0 || z !== 0) begin
      errors++;
      $display("FAIL ignore_start_next: got q=%0d r=%0d dz=%0d, want 3 0 0", q, r, z);
    end
  endtask

  task automatic test_reset_abort();
    int q, r, z, lat, bc, da, za, qa, ra;
    int seen_done;
    bit to;
    @(negedge clk);
    start = 1'b1;
    in1 = 4'd13;
    in2 = 4'd3;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%0b done=%0b dz=%0b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", seen_done);
    end
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    in1 = 4'd9;
    in2 = 4'd0;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_with_start: got busy=%0b done=%0b dz=%0b, want 0 0 0",
               busy, done, div_by_zero);
    end
    run_op(9, 2, 1'b0, q, r, z, lat, bc, da, za, qa, ra, to);
    checks++;
    if (to || q !== 4 || r !== 1 || z !== 0) begin
      errors++;
      $display("FAIL abort_recover_9_2: got q=%0d r=%0d dz=%0d, want 4 1 0", q, r, z);
    end
  endtask

  task automatic test_back_to_back();
    int q, r, z, lat, bc, da, za, qa, ra, eq, er, ez;
    bit to;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        run_op(a, b, 1'b0, q, r, z, lat, bc, da, za, qa, ra, to);
        ref_div(a, b, eq, er, ez);
        checks++;
        if (to || q !== eq || r !== er || z !== ez || lat !== ref_lat(b)) begin
          errors++;
          $display("FAIL exhaustive_%0d_%0d: got q=%0d r=%0d dz=%0d lat=%0d, want q=%0d r=%0d dz=%0d lat=%0d",
                   a, b, q, r, z, lat, eq, er, ez, ref_lat(b));
        end
      end
    end
  endtask

  task automatic test_random();
    int a, b, q, r, z, lat, bc, da, za, qa, ra, eq, er, ez;
    bit to;
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      run_op(a, b, 1'b1, q, r, z, lat, bc, da, za, qa, ra, to);
      ref_div(a, b, eq, er, ez);
      checks++;
      if (to || q !== eq || r !== er || z !== ez || bc !== ref_lat(b)) begin
        errors++;
        $display("FAIL random_%0d_%0d: got q=%0d r=%0d dz=%0d busy=%0d, want q=%0d r=%0d dz=%0d busy=%0d",
                 a, b, q, r, z, bc, eq, er, ez, ref_lat(b));
      end
      checks++;
      if (da !== 0 || za !== 0 || qa !== eq || ra !== er) begin
        errors++;
        $display("FAIL random_hold_%0d_%0d: got done=%0d dz=%0d q=%0d r=%0d, want 0 0 %0d %0d",
                 a, b, da, za, qa, ra, eq, er);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_edges();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
